// File: rtl/hs_enc_pkg.sv
// Shared definitions for the C-PHY HS wire encoder: wire-state codes, symbol
// field positions, FSM state encoding and the wire drive table.
// Optional feature macro used by the encoder: HS_ENC_ERR_CNT_EN.
package hs_enc_pkg;

  // Wire-state codes: sign in the low bit of (code-1), phase in the upper bits.
  localparam logic [2:0] WS_NONE  = 3'b000;
  localparam logic [2:0] WS_POS_X = 3'b001;
  localparam logic [2:0] WS_NEG_X = 3'b010;
  localparam logic [2:0] WS_POS_Y = 3'b011;
  localparam logic [2:0] WS_NEG_Y = 3'b100;
  localparam logic [2:0] WS_POS_Z = 3'b101;
  localparam logic [2:0] WS_NEG_Z = 3'b110;

  // Phase indices, clockwise order x -> y -> z -> x.
  localparam logic [1:0] PH_X = 2'd0;
  localparam logic [1:0] PH_Y = 2'd1;
  localparam logic [1:0] PH_Z = 2'd2;

  // Symbol field positions within {Flip, Rotation, Polarity}.
  localparam int SYM_FLIP = 2;
  localparam int SYM_ROT  = 1;
  localparam int SYM_POL  = 0;

  // Symbol applied every post-amble cycle, and the remap target for illegal codes.
  localparam logic [2:0] SYM_POST = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_POST   = 2'd2
  } enc_state_t;

  typedef struct packed {
    logic [2:0] hi;
    logic [2:0] lo;
  } wire_drive_t;

  // Pull-high / pull-low enables for wires {A,B,C}; the third wire floats mid.
  function automatic wire_drive_t drive_for(input logic [2:0] code);
    wire_drive_t d;
    d.hi = 3'b000;
    d.lo = 3'b000;
    case (code)
      WS_POS_X: begin d.hi = 3'b100; d.lo = 3'b010; end
      WS_NEG_X: begin d.hi = 3'b010; d.lo = 3'b100; end
      WS_POS_Y: begin d.hi = 3'b010; d.lo = 3'b001; end
      WS_NEG_Y: begin d.hi = 3'b001; d.lo = 3'b010; end
      WS_POS_Z: begin d.hi = 3'b001; d.lo = 3'b100; end
      WS_NEG_Z: begin d.hi = 3'b100; d.lo = 3'b001; end
      default:  begin d.hi = 3'b000; d.lo = 3'b000; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hs_wire_next_state.sv
// Combinational C-PHY symbol-to-wire-state step. Illegal symbols (Flip=1 with
// Rotation or Polarity set) are remapped to a plain flip and flagged.
module hs_wire_next_state
  import hs_enc_pkg::*;
(
  input  logic [2:0] state,
  input  logic [2:0] sym,
  output logic [2:0] next_state,
  output logic       illegal
);

  logic [2:0] eff_sym;
  logic [1:0] cur_phase;
  logic       cur_neg;
  logic       cur_valid;
  logic [1:0] nxt_phase;
  logic       nxt_neg;

  assign illegal = sym[SYM_FLIP] & (sym[SYM_ROT] | sym[SYM_POL]);
  assign eff_sym = illegal ? SYM_POST : sym;

  // Split the current state code into phase and sign.
  always_comb begin
    cur_phase = PH_X;
    cur_neg   = 1'b0;
    cur_valid = 1'b1;
    case (state)
      WS_POS_X: begin cur_phase = PH_X; cur_neg = 1'b0; end
      WS_NEG_X: begin cur_phase = PH_X; cur_neg = 1'b1; end
      WS_POS_Y: begin cur_phase = PH_Y; cur_neg = 1'b0; end
      WS_NEG_Y: begin cur_phase = PH_Y; cur_neg = 1'b1; end
      WS_POS_Z: begin cur_phase = PH_Z; cur_neg = 1'b0; end
      WS_NEG_Z: begin cur_phase = PH_Z; cur_neg = 1'b1; end
      default:  cur_valid = 1'b0;
    endcase
  end

  // Apply flip, or rotate the phase and optionally invert the sign.
  always_comb begin
    nxt_phase = cur_phase;
    nxt_neg   = cur_neg;
    if (eff_sym[SYM_FLIP]) begin
      nxt_neg = ~cur_neg;
    end else begin
      if (eff_sym[SYM_ROT]) begin
        case (cur_phase)
          PH_X:    nxt_phase = PH_Y;
          PH_Y:    nxt_phase = PH_Z;
          default: nxt_phase = PH_X;
        endcase
      end else begin
        case (cur_phase)
          PH_X:    nxt_phase = PH_Z;
          PH_Y:    nxt_phase = PH_X;
          default: nxt_phase = PH_Y;
        endcase
      end
      nxt_neg = cur_neg ^ eff_sym[SYM_POL];
    end
  end

  // Re-encode phase and sign; a NONE or unused code stays NONE.
  always_comb begin
    next_state = WS_NONE;
    if (cur_valid) begin
      case (nxt_phase)
        PH_X:    next_state = nxt_neg ? WS_NEG_X : WS_POS_X;
        PH_Y:    next_state = nxt_neg ? WS_NEG_Y : WS_POS_Y;
        default: next_state = nxt_neg ? WS_NEG_Z : WS_POS_Z;
      endcase
    end
  end

endmodule

// File: rtl/hs_wire_encoder.sv
// C-PHY HS 3-wire encoder: turns serialized symbols into wire states, drives
// the per-wire high/low enables and appends a post-amble after each burst.
// Optional feature macro: HS_ENC_ERR_CNT_EN adds a saturating ErrCnt output.
module hs_wire_encoder
  import hs_enc_pkg::*;
#(
  parameter logic [2:0] INIT_STATE = 3'b001,
  parameter int         POST_LEN   = 7
) (
  input  logic       TxSymbolClkHS,
  input  logic       rst,
  input  logic [2:0] SerSym,
  input  logic       SymValid,
  input  logic       EncoderEn,
  output logic [2:0] WireHi,
  output logic [2:0] WireLo,
  output logic [2:0] WireState,
  output logic       EncActive,
  output logic       SymErr
`ifdef HS_ENC_ERR_CNT_EN
  ,
  output logic [7:0] ErrCnt
`endif
);

  // POST_LEN must lie in 1..15 so it fits the 4-bit post counter.
  localparam logic [3:0] POST_LOAD = 4'(POST_LEN);

  enc_state_t  fsm;
  logic [2:0]  wire_state;
  logic [3:0]  post_cnt;
  logic        sym_err;
  logic [2:0]  step_sym;
  logic [2:0]  step_state;
  logic        step_illegal;
  logic        accept_sym;
  logic        accept_illegal;
  wire_drive_t drive;

  // In POST the fixed post-amble symbol replaces the serializer input.
  assign step_sym = (fsm == ST_POST) ? SYM_POST : SerSym;

  hs_wire_next_state u_next (
    .state      (wire_state),
    .sym        (step_sym),
    .next_state (step_state),
    .illegal    (step_illegal)
  );

  // A symbol is taken only in ACTIVE while the burst continues this cycle.
  assign accept_sym     = (fsm == ST_ACTIVE) && EncoderEn && SymValid;
  assign accept_illegal = accept_sym && step_illegal;

  // Burst FSM, wire-state register, post counter and sticky error flag.
  always_ff @(posedge TxSymbolClkHS) begin
    if (rst) begin
      fsm        <= ST_IDLE;
      wire_state <= WS_NONE;
      post_cnt   <= 4'd0;
      sym_err    <= 1'b0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          wire_state <= WS_NONE;
          post_cnt   <= 4'd0;
          if (EncoderEn) begin
            fsm        <= ST_ACTIVE;
            wire_state <= INIT_STATE;
            sym_err    <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (!EncoderEn) begin
            fsm      <= ST_POST;
            post_cnt <= POST_LOAD;
          end else if (SymValid) begin
            wire_state <= step_state;
            if (step_illegal) begin
              sym_err <= 1'b1;
            end
          end
        end
        ST_POST: begin
          if (post_cnt != 4'd0) begin
            wire_state <= step_state;
            post_cnt   <= post_cnt - 4'd1;
          end else begin
            fsm        <= ST_IDLE;
            wire_state <= WS_NONE;
          end
        end
        default: begin
          fsm        <= ST_IDLE;
          wire_state <= WS_NONE;
          post_cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef HS_ENC_ERR_CNT_EN
  logic [7:0] err_cnt;

  // Saturating count of illegal symbols; survives burst re-entry, cleared by rst.
  always_ff @(posedge TxSymbolClkHS) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (accept_illegal && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign ErrCnt = err_cnt;
`else
  logic unused_accept;
  assign unused_accept = accept_illegal;
`endif

  assign drive     = drive_for(wire_state);
  assign WireHi    = drive.hi;
  assign WireLo    = drive.lo;
  assign WireState = wire_state;
  assign EncActive = (fsm != ST_IDLE);
  assign SymErr    = sym_err;

endmodule

// File: tb/tb_hs_wire_encoder.sv
// Directed self-checking bench for hs_wire_encoder with a behavioural model
// feeding a scoreboard. Define HS_ENC_ERR_CNT_EN to also check ErrCnt.
module tb_hs_wire_encoder;

  logic       clk;
  logic       rst;
  logic [2:0] SerSym;
  logic       SymValid;
  logic       EncoderEn;
  logic [2:0] WireHi;
  logic [2:0] WireLo;
  logic [2:0] WireState;
  logic       EncActive;
  logic       SymErr;
`ifdef HS_ENC_ERR_CNT_EN
  logic [7:0] ErrCnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [2:0] ws;
    logic [2:0] hi;
    logic [2:0] lo;
    logic       act;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  localparam int M_IDLE = 0;
  localparam int M_ACT  = 1;
  localparam int M_POST = 2;

  int         m_fsm    = M_IDLE;
  logic [2:0] m_ws     = 3'b000;
  int         m_cnt    = 0;
  logic       m_err    = 1'b0;
  int         m_errcnt = 0;

  hs_wire_encoder #(.INIT_STATE(3'b001), .POST_LEN(7)) dut (
    .TxSymbolClkHS (clk),
    .rst           (rst),
    .SerSym        (SerSym),
    .SymValid      (SymValid),
    .EncoderEn     (EncoderEn),
    .WireHi        (WireHi),
    .WireLo        (WireLo),
    .WireState     (WireState),
    .EncActive     (EncActive),
    .SymErr        (SymErr)
`ifdef HS_ENC_ERR_CNT_EN
    ,
    .ErrCnt        (ErrCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model next state: code-1 = 2*phase + sign, phase arithmetic mod 3.
  function automatic logic [2:0] modelNext(input logic [2:0] ws, input logic [2:0] s);
    int ph;
    int ng;
    if (ws == 3'b000 || ws == 3'b111) return 3'b000;
    ph = (int'(ws) - 1) / 2;
    ng = (int'(ws) - 1) % 2;
    if (s[2]) begin
      ng = 1 - ng;
    end else begin
      ph = s[1] ? (ph + 1) % 3 : (ph + 2) % 3;
      if (s[0]) ng = 1 - ng;
    end
    return 3'(ph * 2 + ng + 1);
  endfunction

  // Model drive: positive state pulls the phase's lead wire high, next wire low.
  function automatic logic [5:0] modelDrive(input logic [2:0] ws);
    int ph;
    int ng;
    int a;
    int b;
    logic [2:0] hi;
    logic [2:0] lo;
    if (ws == 3'b000 || ws == 3'b111) return 6'b000000;
    ph = (int'(ws) - 1) / 2;
    ng = (int'(ws) - 1) % 2;
    a = ph;
    b = (ph + 1) % 3;
    hi = 3'b100 >> (ng ? b : a);
    lo = 3'b100 >> (ng ? a : b);
    return {hi, lo};
  endfunction

  task automatic modelStep(input logic r, input logic en, input logic v, input logic [2:0] s);
    logic [2:0] sym;
    if (r) begin
      m_fsm = M_IDLE; m_ws = 3'b000; m_cnt = 0; m_err = 1'b0; m_errcnt = 0;
    end else begin
      case (m_fsm)
        M_IDLE: begin
          m_ws = 3'b000;
          if (en) begin
            m_fsm = M_ACT; m_ws = 3'b001; m_err = 1'b0;
          end
        end
        M_ACT: begin
          if (!en) begin
            m_fsm = M_POST; m_cnt = 7;
          end else if (v) begin
            sym = s;
            if (s >= 3'd5) begin
              sym = 3'b100;
              m_err = 1'b1;
              if (m_errcnt < 255) m_errcnt++;
            end
            m_ws = modelNext(m_ws, sym);
          end
        end
        default: begin
          if (m_cnt > 0) begin
            m_ws = modelNext(m_ws, 3'b100);
            m_cnt--;
          end else begin
            m_fsm = M_IDLE; m_ws = 3'b000;
          end
        end
      endcase
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty got 0 entries required 1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (WireState === e.ws) else begin
        errors++;
        $error("[TB] FAIL %s WireState got %b required %b", e.tag, WireState, e.ws);
      end
      checks++;
      assert (WireHi === e.hi) else begin
        errors++;
        $error("[TB] FAIL %s WireHi got %b required %b", e.tag, WireHi, e.hi);
      end
      checks++;
      assert (WireLo === e.lo) else begin
        errors++;
        $error("[TB] FAIL %s WireLo got %b required %b", e.tag, WireLo, e.lo);
      end
      checks++;
      assert (EncActive === e.act) else begin
        errors++;
        $error("[TB] FAIL %s EncActive got %b required %b", e.tag, EncActive, e.act);
      end
      checks++;
      assert (SymErr === e.err) else begin
        errors++;
        $error("[TB] FAIL %s SymErr got %b required %b", e.tag, SymErr, e.err);
      end
`ifdef HS_ENC_ERR_CNT_EN
      checks++;
      assert (ErrCnt === e.cnt) else begin
        errors++;
        $error("[TB] FAIL %s ErrCnt got %0d required %0d", e.tag, ErrCnt, e.cnt);
      end
`endif
    end
  endtask

  task automatic checkConst(input string tag, input logic [7:0] got, input logic [7:0] req);
    checks++;
    assert (got === req) else begin
      errors++;
      $error("[TB] FAIL %s got %b required %b", tag, got, req);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic v,
                               input logic [2:0] s, input string tag);
    exp_t e;
    logic [5:0] d;
    @(negedge clk);
    rst = r; EncoderEn = en; SymValid = v; SerSym = s;
    modelStep(r, en, v, s);
    d = modelDrive(m_ws);
    e.tag = tag; e.ws = m_ws; e.hi = d[5:3]; e.lo = d[2:0];
    e.act = (m_fsm != M_IDLE); e.err = m_err; e.cnt = 8'(m_errcnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  logic [2:0] legal_seq [5] = '{3'b010, 3'b011, 3'b000, 3'b100, 3'b001};
  logic [2:0] legal_exp [5] = '{3'b011, 3'b110, 3'b100, 3'b011, 3'b010};
  logic [2:0] post_exp  [7] = '{3'b011, 3'b100, 3'b011, 3'b100, 3'b011, 3'b100, 3'b011};
  logic [2:0] held_exp  [7] = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};

  initial begin
    rst = 1'b1; EncoderEn = 1'b0; SymValid = 1'b0; SerSym = 3'b000;

    // Reset for two cycles, then start the burst.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, "reset0");
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, "reset1");
    checkConst("reset_ws", 8'(WireState), 8'b000);
    checkConst("reset_hi", 8'(WireHi), 8'b000);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, "entry");
    checkConst("entry_ws", 8'(WireState), 8'b001);
    checkConst("entry_hi", 8'(WireHi), 8'b100);
    checkConst("entry_lo", 8'(WireLo), 8'b010);
    checkConst("entry_act", 8'(EncActive), 8'd1);

    // Legal symbol sequence from +x.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, legal_seq[i], "legal");
      checkConst("legal_ws", 8'(WireState), 8'(legal_exp[i]));
    end
    checkConst("legal_hi", 8'(WireHi), 8'b010);
    checkConst("legal_lo", 8'(WireLo), 8'b100);

    // Hold with SymValid low.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 3'b111, "hold");
      checkConst("hold_ws", 8'(WireState), 8'b010);
    end

    // Move to +y, then an illegal symbol, then show the flag is sticky.
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b011, "to_pos_y");
    checkConst("to_pos_y_ws", 8'(WireState), 8'b011);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b111, "illegal");
    checkConst("illegal_ws", 8'(WireState), 8'b100);
    checkConst("illegal_err", 8'(SymErr), 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b100, "sticky0");
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b100, "sticky1");
    checkConst("sticky_err", 8'(SymErr), 8'd1);

    // Long run of illegal symbols to saturate the optional counter.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 3'(5 + (i % 3)), "illegal_run");
    end
`ifdef HS_ENC_ERR_CNT_EN
    checkConst("errcnt_sat", ErrCnt, 8'd255);
`endif
    checkConst("run_end_ws", 8'(WireState), 8'b100);

    // EncoderEn falls at -y; the symbol in that cycle is dropped.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, "post_enter");
    checkConst("post_enter_ws", 8'(WireState), 8'b100);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 3'b011, "post");
      checkConst("post_ws", 8'(WireState), 8'(post_exp[i]));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, "post_done");
    checkConst("post_done_ws", 8'(WireState), 8'b000);
    checkConst("post_done_act", 8'(EncActive), 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, "reentry");
    checkConst("reentry_ws", 8'(WireState), 8'b001);
    checkConst("reentry_err", 8'(SymErr), 8'd0);

    // EncoderEn held high through POST re-enters after one IDLE cycle.
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, "held_enter");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 3'b001, "held_post");
      checkConst("held_post_ws", 8'(WireState), 8'(held_exp[i]));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, "held_idle");
    checkConst("held_idle_ws", 8'(WireState), 8'b000);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, "held_reentry");
    checkConst("held_reentry_ws", 8'(WireState), 8'b001);

    // Reset on the third post-amble cycle.
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b101, "pre_rst_illegal");
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, "rst_post_enter");
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, "rst_post1");
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, "rst_post2");
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, "rst_post3");
    checkConst("rst_post_ws", 8'(WireState), 8'b000);
    checkConst("rst_post_act", 8'(EncActive), 8'd0);
    checkConst("rst_post_err", 8'(SymErr), 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, "rst_reentry");
    checkConst("rst_reentry_ws", 8'(WireState), 8'b001);
    checkConst("rst_reentry_err", 8'(SymErr), 8'd0);
`ifdef HS_ENC_ERR_CNT_EN
    checkConst("rst_errcnt", ErrCnt, 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
